// File: rtl/m68k_region_decoder_dtack.sv
// Registered 68k bus region decoder: programmable base/mask chip selects,
// per-region wait states, optional external DTACK and a bus-error watchdog.
module m68k_region_decoder_dtack #(
  parameter int NUM_REGIONS    = 4,
  parameter int ADDR_W         = 32,
  parameter int WAIT_W         = 4,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE =
    {32'h0800_0000, 32'h0040_0000, 32'hF000_0000, 32'h0000_0000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK =
    {32'hFC00_0000, 32'hFFFF_0000, 32'hFFFC_0000, 32'hFFFF_8000},
  parameter logic [NUM_REGIONS*WAIT_W-1:0] REGION_WAIT =
    {4'd3, 4'd2, 4'd1, 4'd0},
  parameter logic [NUM_REGIONS-1:0] REGION_EXT = 4'b1100,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   Clk,
  input  logic                   Reset_L,
  input  logic [ADDR_W-1:0]      Address,
  input  logic                   AS_L,
  input  logic                   ExtDtack_L,
  output logic [NUM_REGIONS-1:0] Select_H,
  output logic                   Dtack_L,
  output logic                   Berr_L,
  output logic                   Busy_H
);

  localparam int TO_W = 10;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_EXTWAIT,
    S_ACK,
    S_BERR
  } state_t;

  state_t                 r_state;
  state_t                 w_stateNext;
  logic [NUM_REGIONS-1:0] r_select;
  logic [NUM_REGIONS-1:0] w_selectNext;
  logic [WAIT_W-1:0]      r_waitCnt;
  logic [WAIT_W-1:0]      w_waitCntNext;
  logic [TO_W-1:0]        r_toCnt;
  logic [TO_W-1:0]        w_toCntNext;
  logic                   r_ext;
  logic                   w_extNext;

  logic                   w_hitAny;
  logic [NUM_REGIONS-1:0] w_onehot;
  logic [WAIT_W-1:0]      w_hitWait;
  logic                   w_hitExt;
  logic                   w_timeout;

  // Scanning from the top index down lets the lowest-index hit overwrite the rest.
  always_comb begin
    w_hitAny  = 1'b0;
    w_onehot  = '0;
    w_hitWait = '0;
    w_hitExt  = 1'b0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((Address & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]) begin
        w_hitAny     = 1'b1;
        w_onehot     = '0;
        w_onehot[i]  = 1'b1;
        w_hitWait    = REGION_WAIT[i*WAIT_W +: WAIT_W];
        w_hitExt     = REGION_EXT[i];
      end
    end
  end

  assign w_timeout = (r_toCnt == TO_LAST);

  // An abort beats everything; a completed handshake beats a coinciding timeout.
  always_comb begin
    w_stateNext   = r_state;
    w_selectNext  = r_select;
    w_waitCntNext = r_waitCnt;
    w_toCntNext   = r_toCnt;
    w_extNext     = r_ext;
    case (r_state)
      S_IDLE: begin
        if (!AS_L) begin
          if (w_hitAny) begin
            w_stateNext   = S_WAIT;
            w_selectNext  = w_onehot;
            w_waitCntNext = w_hitWait;
            w_toCntNext   = '0;
            w_extNext     = w_hitExt;
          end else begin
            w_stateNext  = S_BERR;
            w_selectNext = '0;
          end
        end
      end
      S_WAIT: begin
        w_toCntNext = r_toCnt + TO_W'(1);
        if (AS_L) begin
          w_stateNext  = S_IDLE;
          w_selectNext = '0;
        end else if (r_waitCnt == '0 && !r_ext) begin
          w_stateNext = S_ACK;
        end else if (w_timeout) begin
          w_stateNext = S_BERR;
        end else if (r_waitCnt == '0) begin
          w_stateNext = S_EXTWAIT;
        end else begin
          w_waitCntNext = r_waitCnt - WAIT_W'(1);
        end
      end
      S_EXTWAIT: begin
        w_toCntNext = r_toCnt + TO_W'(1);
        if (AS_L) begin
          w_stateNext  = S_IDLE;
          w_selectNext = '0;
        end else if (!ExtDtack_L) begin
          w_stateNext = S_ACK;
        end else if (w_timeout) begin
          w_stateNext = S_BERR;
        end
      end
      S_ACK, S_BERR: begin
        if (AS_L) begin
          w_stateNext  = S_IDLE;
          w_selectNext = '0;
        end
      end
      default: begin
        w_stateNext  = S_IDLE;
        w_selectNext = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      r_state   <= S_IDLE;
      r_select  <= '0;
      r_waitCnt <= '0;
      r_toCnt   <= '0;
      r_ext     <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_select  <= w_selectNext;
      r_waitCnt <= w_waitCntNext;
      r_toCnt   <= w_toCntNext;
      r_ext     <= w_extNext;
    end
  end

  assign Select_H = r_select;
  assign Dtack_L  = (r_state != S_ACK);
  assign Berr_L   = (r_state != S_BERR);
  assign Busy_H   = (r_state != S_IDLE);

endmodule

// File: tb/tb_m68k_region_decoder_dtack.sv
// Directed bench for m68k_region_decoder_dtack: decode, wait states, external
// DTACK, timeout, abort and asynchronous reset, with hand-computed expectations.
module tb_m68k_region_decoder_dtack;

  logic        Clk;
  logic        Reset_L;
  logic [31:0] Address;
  logic        AS_L;
  logic        ExtDtack_L;
  logic [3:0]  Select_H;
  logic        Dtack_L;
  logic        Berr_L;
  logic        Busy_H;

  int passCnt  = 0;
  int failCnt  = 0;
  int totalCnt = 0;

  m68k_region_decoder_dtack #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .Clk       (Clk),
    .Reset_L   (Reset_L),
    .Address   (Address),
    .AS_L      (AS_L),
    .ExtDtack_L(ExtDtack_L),
    .Select_H  (Select_H),
    .Dtack_L   (Dtack_L),
    .Berr_L    (Berr_L),
    .Busy_H    (Busy_H)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic as_l, input logic ext_l);
    Address    = addr;
    AS_L       = as_l;
    ExtDtack_L = ext_l;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] sel, input logic dtack,
                             input logic berr, input logic busy);
    checkVal({tag, ".sel"},   32'(Select_H), 32'(sel));
    checkVal({tag, ".dtack"}, 32'(Dtack_L),  32'(dtack));
    checkVal({tag, ".berr"},  32'(Berr_L),   32'(berr));
    checkVal({tag, ".busy"},  32'(Busy_H),   32'(busy));
  endtask

  initial begin
    Reset_L = 1'b0;
    applyStimulus(32'h0, 1'b1, 1'b1);
    #3;
    checkOutput("reset", 4'b0000, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    Reset_L = 1'b1;
    tick();
    checkOutput("idle", 4'b0000, 1'b1, 1'b1, 1'b0);

    $display("[TB] ROM read, zero wait states");
    applyStimulus(32'h0000_1000, 1'b0, 1'b1);
    tick();
    checkOutput("rom_e0", 4'b0001, 1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("rom_e1", 4'b0001, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("rom_hold", 4'b0001, 1'b0, 1'b1, 1'b1);
    applyStimulus(32'h0000_1000, 1'b1, 1'b1);
    tick();
    checkOutput("rom_end", 4'b0000, 1'b1, 1'b1, 1'b0);

    $display("[TB] RAM back-to-back, one wait state, ExtDtack_L ignored");
    applyStimulus(32'hF002_0000, 1'b0, 1'b0);
    tick();
    checkOutput("ram_e0", 4'b0010, 1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("ram_e1", 4'b0010, 1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("ram_e2", 4'b0010, 1'b0, 1'b1, 1'b1);
    applyStimulus(32'hF002_0000, 1'b1, 1'b1);
    tick();
    checkOutput("ram_end", 4'b0000, 1'b1, 1'b1, 1'b0);

    applyStimulus(32'hF003_FFFF, 1'b0, 1'b1);
    tick();
    checkOutput("ramtop_e0", 4'b0010, 1'b1, 1'b1, 1'b1);
    applyStimulus(32'h0040_0000, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("ramtop_e2", 4'b0010, 1'b0, 1'b1, 1'b1);
    applyStimulus(32'hF003_FFFF, 1'b1, 1'b1);
    tick();

    $display("[TB] Unmapped access just above RAM");
    applyStimulus(32'hF004_0000, 1'b0, 1'b1);
    tick();
    checkOutput("unmap_e0", 4'b0000, 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("unmap_hold", 4'b0000, 1'b1, 1'b0, 1'b1);
    applyStimulus(32'hF004_0000, 1'b1, 1'b1);
    tick();
    checkOutput("unmap_end", 4'b0000, 1'b1, 1'b1, 1'b0);

    $display("[TB] IO with external DTACK");
    applyStimulus(32'h0040_0010, 1'b0, 1'b1);
    tick();
    checkOutput("io_e0", 4'b0100, 1'b1, 1'b1, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      checkOutput($sformatf("io_e%0d", k), 4'b0100, 1'b1, 1'b1, 1'b1);
    end
    ExtDtack_L = 1'b0;
    tick();
    checkOutput("io_ext", 4'b0100, 1'b0, 1'b1, 1'b1);
    applyStimulus(32'h0040_0010, 1'b1, 1'b1);
    tick();
    checkOutput("io_end", 4'b0000, 1'b1, 1'b1, 1'b0);

    $display("[TB] DRAM timeout to BERR");
    applyStimulus(32'h0900_0000, 1'b0, 1'b1);
    tick();
    checkOutput("dram_e0", 4'b1000, 1'b1, 1'b1, 1'b1);
    for (int k = 1; k <= 15; k++) begin
      tick();
      checkOutput($sformatf("dram_e%0d", k), 4'b1000, 1'b1, 1'b1, 1'b1);
    end
    tick();
    checkOutput("dram_e16", 4'b1000, 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("dram_hold", 4'b1000, 1'b1, 1'b0, 1'b1);
    applyStimulus(32'h0900_0000, 1'b1, 1'b1);
    tick();
    checkOutput("dram_end", 4'b0000, 1'b1, 1'b1, 1'b0);

    $display("[TB] DRAM ExtDtack_L coinciding with timeout");
    applyStimulus(32'h0A00_0000, 1'b0, 1'b1);
    tick();
    for (int k = 1; k <= 15; k++) tick();
    checkOutput("race_e15", 4'b1000, 1'b1, 1'b1, 1'b1);
    ExtDtack_L = 1'b0;
    tick();
    checkOutput("race_e16", 4'b1000, 1'b0, 1'b1, 1'b1);
    applyStimulus(32'h0A00_0000, 1'b1, 1'b1);
    tick();

    $display("[TB] Abort during RAM wait, then ROM");
    applyStimulus(32'hF000_0100, 1'b0, 1'b1);
    tick();
    checkOutput("abort_e0", 4'b0010, 1'b1, 1'b1, 1'b1);
    AS_L = 1'b1;
    tick();
    checkOutput("abort_e1", 4'b0000, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h0000_0004, 1'b0, 1'b1);
    tick();
    checkOutput("abort_e2", 4'b0001, 1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("abort_e3", 4'b0001, 1'b0, 1'b1, 1'b1);
    AS_L = 1'b1;
    tick();

    $display("[TB] Asynchronous reset during EXTWAIT");
    applyStimulus(32'h0040_0020, 1'b0, 1'b1);
    for (int k = 0; k <= 4; k++) tick();
    checkOutput("rst_pre", 4'b0100, 1'b1, 1'b1, 1'b1);
    #2;
    Reset_L = 1'b0;
    #1;
    checkOutput("rst_async", 4'b0000, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h0040_0020, 1'b1, 1'b1);
    tick();
    Reset_L = 1'b1;
    tick();
    checkOutput("rst_idle", 4'b0000, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h0000_2000, 1'b0, 1'b1);
    tick();
    checkOutput("rst_rom_e0", 4'b0001, 1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("rst_rom_e1", 4'b0001, 1'b0, 1'b1, 1'b1);
    AS_L = 1'b1;
    tick();
    checkOutput("rst_rom_end", 4'b0000, 1'b1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
